// File: rtl/mem_bus_arbiter.sv
// mem_bus_arbiter
//   Shares one 8-bit memory bus between the CPU (port 0) and the DMA/IO
//   engine (port 1). Each access is a fixed-latency transaction:
//   grant -> WAIT_STATES+1 cycles of mem_en -> one-cycle ack.
//   Simultaneous requests are resolved either round-robin or with fixed CPU
//   priority. A port may hold the bus across several accesses with lock.
//
// Parameters
//   WAIT_STATES   extra memory cycles per access (0..15)
//   CPU_PRIORITY  1: port 0 always wins a tie, 0: round-robin
//
// Ports
//   clk, reset_cycle         clock (rising edge), async active-high reset
//   req, lock, we [1:0]      per-port request / bus hold / write enable
//   addr0/1, wdata0/1        per-port address and write data
//   gnt [1:0]                one-hot owner (level)
//   ack [1:0]                one-cycle completion pulse to the owner
//   rdata                    read data, holds until the next read completes
//   busy                     FSM is not idle
//   mem_en, mem_we           memory access / write strobes
//   mem_addr, mem_wdata      memory address / write data
//   mem_rdata                memory read data, valid on the final access cycle
module mem_bus_arbiter #(
  parameter int unsigned WAIT_STATES  = 0,
  parameter int unsigned CPU_PRIORITY = 0
) (
  input  logic       clk,
  input  logic       reset_cycle,
  input  logic [1:0] req,
  input  logic [1:0] lock,
  input  logic [1:0] we,
  input  logic [7:0] addr0,
  input  logic [7:0] addr1,
  input  logic [7:0] wdata0,
  input  logic [7:0] wdata1,
  output logic [1:0] gnt,
  output logic [1:0] ack,
  output logic [7:0] rdata,
  output logic       busy,
  output logic       mem_en,
  output logic       mem_we,
  output logic [7:0] mem_addr,
  output logic [7:0] mem_wdata,
  input  logic [7:0] mem_rdata
);

  localparam logic [3:0] WAIT_INIT = 4'(WAIT_STATES);

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    ACCESS = 2'd1,
    ACK    = 2'd2
  } state_t;

  state_t      state_q, state_d;
  logic [3:0]  wait_cnt_q, wait_cnt_d;
  logic        locked_q, locked_d;
  logic        owner_q, owner_d;
  logic        last_owner_q, last_owner_d;
  logic [1:0]  gnt_q, gnt_d;
  logic [1:0]  ack_q, ack_d;
  logic [7:0]  rdata_q, rdata_d;
  logic        busy_q, busy_d;
  logic        mem_en_q, mem_en_d;
  logic        mem_we_q, mem_we_d;
  logic [7:0]  mem_addr_q, mem_addr_d;
  logic [7:0]  mem_wdata_q, mem_wdata_d;

  // start/start_port: an access begins this cycle for the given port
  logic        start;
  logic        start_port;

  always_comb begin
    state_d      = state_q;
    wait_cnt_d   = wait_cnt_q;
    locked_d     = locked_q;
    owner_d      = owner_q;
    last_owner_d = last_owner_q;
    gnt_d        = gnt_q;
    ack_d        = 2'b00;
    rdata_d      = rdata_q;
    mem_en_d     = mem_en_q;
    mem_we_d     = mem_we_q;
    mem_addr_d   = mem_addr_q;
    mem_wdata_d  = mem_wdata_q;
    start        = 1'b0;
    start_port   = owner_q;

    unique case (state_q)
      IDLE: begin
        if (locked_q) begin
          // Bus is held: only the owner is served. Releasing the lock frees
          // the bus this cycle; arbitration resumes on the next one.
          if (!lock[owner_q]) begin
            locked_d = 1'b0;
            gnt_d    = 2'b00;
          end else if (req[owner_q]) begin
            start      = 1'b1;
            start_port = owner_q;
          end
        end else begin
          unique case (req)
            2'b01: begin
              start      = 1'b1;
              start_port = 1'b0;
            end
            2'b10: begin
              start      = 1'b1;
              start_port = 1'b1;
            end
            2'b11: begin
              start      = 1'b1;
              start_port = (CPU_PRIORITY != 0) ? 1'b0 : ~last_owner_q;
            end
            default: begin
              start = 1'b0;
            end
          endcase
        end
      end

      ACCESS: begin
        if (wait_cnt_q == 4'd0) begin
          // rdata only moves on reads so it survives intervening writes
          if (!mem_we_q) begin
            rdata_d = mem_rdata;
          end
          mem_en_d       = 1'b0;
          mem_we_d       = 1'b0;
          ack_d[owner_q] = 1'b1;
          last_owner_d   = owner_q;
          state_d        = ACK;
        end else begin
          wait_cnt_d = wait_cnt_q - 4'd1;
        end
      end

      ACK: begin
        if (lock[owner_q] && req[owner_q]) begin
          // Locked back-to-back access skips IDLE entirely
          start      = 1'b1;
          start_port = owner_q;
        end else if (lock[owner_q]) begin
          locked_d = 1'b1;
          state_d  = IDLE;
        end else begin
          gnt_d    = 2'b00;
          locked_d = 1'b0;
          state_d  = IDLE;
        end
      end

      default: begin
        state_d = IDLE;
      end
    endcase

    if (start) begin
      owner_d     = start_port;
      gnt_d       = start_port ? 2'b10 : 2'b01;
      mem_addr_d  = start_port ? addr1 : addr0;
      mem_wdata_d = start_port ? wdata1 : wdata0;
      mem_we_d    = we[start_port];
      mem_en_d    = 1'b1;
      wait_cnt_d  = WAIT_INIT;
      state_d     = ACCESS;
    end

    busy_d = (state_d != IDLE);
  end

  always_ff @(posedge clk or posedge reset_cycle) begin
    if (reset_cycle) begin
      state_q      <= IDLE;
      wait_cnt_q   <= 4'd0;
      locked_q     <= 1'b0;
      owner_q      <= 1'b0;
      last_owner_q <= 1'b1;
      gnt_q        <= 2'b00;
      ack_q        <= 2'b00;
      rdata_q      <= 8'h00;
      busy_q       <= 1'b0;
      mem_en_q     <= 1'b0;
      mem_we_q     <= 1'b0;
      mem_addr_q   <= 8'h00;
      mem_wdata_q  <= 8'h00;
    end else begin
      state_q      <= state_d;
      wait_cnt_q   <= wait_cnt_d;
      locked_q     <= locked_d;
      owner_q      <= owner_d;
      last_owner_q <= last_owner_d;
      gnt_q        <= gnt_d;
      ack_q        <= ack_d;
      rdata_q      <= rdata_d;
      busy_q       <= busy_d;
      mem_en_q     <= mem_en_d;
      mem_we_q     <= mem_we_d;
      mem_addr_q   <= mem_addr_d;
      mem_wdata_q  <= mem_wdata_d;
    end
  end

  assign gnt       = gnt_q;
  assign ack       = ack_q;
  assign rdata     = rdata_q;
  assign busy      = busy_q;
  assign mem_en    = mem_en_q;
  assign mem_we    = mem_we_q;
  assign mem_addr  = mem_addr_q;
  assign mem_wdata = mem_wdata_q;

endmodule
